// File: rtl/dp_memory_pkg.sv
// Shared types and constants for the dual-port byte-enabled memory.
package dp_memory_pkg;

    // Controller states: CLEAR sweeps zeros through the array, READY serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Legal range of the read latency parameter.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Default parameter values for dp_memory.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DEPTH      = 16384;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_INIT_CLEAR = 1;

    // True when v is a power of two and at least 2 (clearing works on word pairs).
    function automatic bit is_pow2_ge2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/dp_memory_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid/data with a held output.
module dp_memory_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] r_dat [RD_LAT];

    // Shift valid every cycle; a data stage loads only when a valid word
    // arrives, so the last stage holds the most recent delivered word.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every stage samples
        // the previous stage's pre-edge value, independent of statement order.
        if (!reset_n) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/dp_memory.sv
// Dual-port, byte-enabled, read-first memory with optional zero-fill after reset.
module dp_memory
    import dp_memory_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int INIT_CLEAR = DEF_INIT_CLEAR
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   addr_1,
    input  logic [DATA_W-1:0]   din_1,
    input  logic [DATA_W/8-1:0] be_1,
    input  logic                re_1,
    input  logic                we_1,
    output logic [DATA_W-1:0]   dout_1,
    output logic                rvalid_1,
    output logic                err_1,
    input  logic [ADDR_W-1:0]   addr_2,
    input  logic [DATA_W-1:0]   din_2,
    input  logic [DATA_W/8-1:0] be_2,
    input  logic                re_2,
    input  logic                we_2,
    output logic [DATA_W-1:0]   dout_2,
    output logic                rvalid_2,
    output logic                err_2,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // Reject unsupported configurations at elaboration.
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $fatal(1, "dp_memory: RD_LAT out of range 1..4");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $fatal(1, "dp_memory: DATA_W must be a multiple of 8");
    end
    if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
        $fatal(1, "dp_memory: DEPTH must be a power of two");
    end

    // Aligned and inside the array: no low byte bits, nothing above the index.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ((a & ADDR_W'(BYTES - 1)) == '0) && ((a >> (LSB + IDX_W)) == '0);
    endfunction

    state_t            r_state;
    state_t            w_state_nx;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              w_clr_we;
    logic [IDX_W-1:0]  w_clr_lo;
    logic [IDX_W-1:0]  w_clr_hi;
    logic              w_busy;
    logic              w_live;

    logic [IDX_W-1:0]  w_idx_1, w_idx_2;
    logic              w_ok_1, w_ok_2;
    logic              w_rd_1, w_rd_2;
    logic              w_wr_1, w_wr_2;
    logic              w_rej_1, w_rej_2;
    logic [DATA_W-1:0] w_rdata_1, w_rdata_2;
    logic              r_err_1, r_err_2;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Controller state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= (INIT_CLEAR != 0) ? CLEAR : READY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and clear-enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nx = r_state;
        w_busy     = 1'b0;
        w_clr_we   = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = reset_n;
                if (r_clr_cnt == IDX_W'(DEPTH / 2 - 1)) begin
                    w_state_nx = READY;
                end
            end
            READY:   w_state_nx = READY;
            default: w_state_nx = READY;
        endcase
    end

    // Word-pair counter for the zero-fill sweep; restarts at 0 on every reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_we) begin
            r_clr_cnt <= r_clr_cnt + IDX_W'(1);
        end
    end

    assign w_clr_lo = IDX_W'({r_clr_cnt, 1'b0});
    assign w_clr_hi = w_clr_lo | IDX_W'(1);
    assign busy     = w_busy;
    assign w_live   = reset_n && !w_busy;

    assign w_idx_1 = IDX_W'(addr_1 >> LSB);
    assign w_idx_2 = IDX_W'(addr_2 >> LSB);
    assign w_ok_1  = addr_ok(addr_1);
    assign w_ok_2  = addr_ok(addr_2);
    assign w_rd_1  = w_live && re_1 && w_ok_1;
    assign w_rd_2  = w_live && re_2 && w_ok_2;
    assign w_wr_1  = w_live && we_1 && w_ok_1;
    assign w_wr_2  = w_live && we_2 && w_ok_2;
    assign w_rej_1 = (re_1 || we_1) && (w_busy || !w_ok_1);
    assign w_rej_2 = (re_2 || we_2) && (w_busy || !w_ok_2);

    // Reads see the array before this edge's writes land, giving read-first behaviour.
    assign w_rdata_1 = r_mem[w_idx_1];
    assign w_rdata_2 = r_mem[w_idx_2];

    // Array update: zero-fill pair, then port 2 lanes, then port 1 lanes so port 1 wins.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset branch; contents survive reset
        // and only the explicit zero-fill sweep clears them.
        if (w_clr_we) begin
            r_mem[w_clr_lo] <= '0;
            r_mem[w_clr_hi] <= '0;
        end
        for (int b = 0; b < BYTES; b++) begin
            if (w_wr_2 && be_2[b]) begin
                r_mem[w_idx_2][8*b +: 8] <= din_2[8*b +: 8];
            end
            if (w_wr_1 && be_1[b]) begin
                r_mem[w_idx_1][8*b +: 8] <= din_1[8*b +: 8];
            end
        end
    end

    // One-cycle error pulse for each rejected request.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_1 <= 1'b0;
            r_err_2 <= 1'b0;
        end else begin
            r_err_1 <= w_rej_1;
            r_err_2 <= w_rej_2;
        end
    end

    assign err_1 = r_err_1;
    assign err_2 = r_err_2;

    dp_memory_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_1 (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_rd_1),
        .i_data  (w_rdata_1),
        .o_valid (rvalid_1),
        .o_data  (dout_1)
    );

    dp_memory_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_2 (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_rd_2),
        .i_data  (w_rdata_2),
        .o_valid (rvalid_2),
        .o_data  (dout_2)
    );

endmodule

// File: tb/tb_dp_memory.sv
// Directed self-checking bench: DUT A (DEPTH=16, RD_LAT=3, zero-fill) and
// DUT B (DEPTH=16, RD_LAT=2, no zero-fill) share one clock.
module tb_dp_memory;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT A signals
    logic        rst_a;
    logic [31:0] addr_a1, din_a1, addr_a2, din_a2;
    logic [3:0]  be_a1, be_a2;
    logic        re_a1, we_a1, re_a2, we_a2;
    logic [31:0] dout_a1, dout_a2;
    logic        rvalid_a1, rvalid_a2, err_a1, err_a2, busy_a;

    // DUT B signals
    logic        rst_b;
    logic [31:0] addr_b1, din_b1, addr_b2, din_b2;
    logic [3:0]  be_b1, be_b2;
    logic        re_b1, we_b1, re_b2, we_b2;
    logic [31:0] dout_b1, dout_b2;
    logic        rvalid_b1, rvalid_b2, err_b1, err_b2, busy_b;

    dp_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(3), .INIT_CLEAR(1)) u_dut_a (
        .clock(clk), .reset_n(rst_a),
        .addr_1(addr_a1), .din_1(din_a1), .be_1(be_a1), .re_1(re_a1), .we_1(we_a1),
        .dout_1(dout_a1), .rvalid_1(rvalid_a1), .err_1(err_a1),
        .addr_2(addr_a2), .din_2(din_a2), .be_2(be_a2), .re_2(re_a2), .we_2(we_a2),
        .dout_2(dout_a2), .rvalid_2(rvalid_a2), .err_2(err_a2),
        .busy(busy_a)
    );

    dp_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(2), .INIT_CLEAR(0)) u_dut_b (
        .clock(clk), .reset_n(rst_b),
        .addr_1(addr_b1), .din_1(din_b1), .be_1(be_b1), .re_1(re_b1), .we_1(we_b1),
        .dout_1(dout_b1), .rvalid_1(rvalid_b1), .err_1(err_b1),
        .addr_2(addr_b2), .din_2(din_b2), .be_2(be_b2), .re_2(re_b2), .we_2(we_b2),
        .dout_2(dout_b2), .rvalid_2(rvalid_b2), .err_2(err_b2),
        .busy(busy_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        addr_a1 = '0; din_a1 = '0; be_a1 = '0; re_a1 = 1'b0; we_a1 = 1'b0;
        addr_a2 = '0; din_a2 = '0; be_a2 = '0; re_a2 = 1'b0; we_a2 = 1'b0;
        addr_b1 = '0; din_b1 = '0; be_b1 = '0; re_b1 = 1'b0; we_b1 = 1'b0;
        addr_b2 = '0; din_b2 = '0; be_b2 = '0; re_b2 = 1'b0; we_b2 = 1'b0;
    endtask

    // Single-cycle write on DUT A port p.
    task automatic a_write(input int p, input logic [31:0] addr, input logic [31:0] din,
                           input logic [3:0] be);
        if (p == 1) begin addr_a1 = addr; din_a1 = din; be_a1 = be; we_a1 = 1'b1; end
        else        begin addr_a2 = addr; din_a2 = din; be_a2 = be; we_a2 = 1'b1; end
        tick;
        we_a1 = 1'b0; we_a2 = 1'b0; be_a1 = '0; be_a2 = '0;
    endtask

    // Single read on DUT A port p; lat is cycles until rvalid, -1 if it never came.
    task automatic a_read(input int p, input logic [31:0] addr, output logic [31:0] data,
                          output int lat);
        lat  = -1;
        data = 'x;
        if (p == 1) begin addr_a1 = addr; re_a1 = 1'b1; end
        else        begin addr_a2 = addr; re_a2 = 1'b1; end
        tick;
        re_a1 = 1'b0; re_a2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if ((p == 1) ? rvalid_a1 : rvalid_a2) begin
                lat  = k;
                data = (p == 1) ? dout_a1 : dout_a2;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b0; rst_b = 1'b0;
        idle_all();
        tick; tick;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a: got %b expected 1", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        checks++; if (rvalid_a1 !== 1'b0 || rvalid_a2 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", rvalid_a1, rvalid_a2); end
        checks++; if (err_a1 !== 1'b0 || err_a2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", err_a1, err_a2); end
        checks++; if (dout_a1 !== 32'h0 || dout_b1 !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h %h expected 0", dout_a1, dout_b1); end
    endtask

    task automatic test_clear;
        int  n_busy;
        bit  saw_rv;
        logic exp_v;
        n_busy = 0;
        saw_rv = 1'b0;
        rst_a   = 1'b1;
        re_a1   = 1'b1;      // request while busy must be rejected
        addr_a1 = 32'h0;
        for (int k = 0; k < 20 && busy_a; k++) begin
            n_busy++;
            tick;
            if (k == 0) begin
                re_a1 = 1'b0;
                checks++; if (err_a1 !== 1'b1) begin errors++; $display("FAIL busy_reject_err: got %b expected 1", err_a1); end
            end
            if (rvalid_a1) saw_rv = 1'b1;
        end
        checks++; if (n_busy != 8) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 8", n_busy); end
        checks++; if (saw_rv) begin errors++; $display("FAIL busy_no_rvalid: got rvalid during clear expected none"); end
        // Back-to-back reads of every index; each returns zero three cycles later.
        for (int c = 0; c < 19; c++) begin
            re_a1   = (c < DEPTH);
            addr_a1 = 32'(4 * c);
            tick;
            exp_v = (c >= 2 && c <= 17);
            checks++; if (rvalid_a1 !== exp_v) begin errors++; $display("FAIL clear_scan_rvalid[%0d]: got %b expected %b", c, rvalid_a1, exp_v); end
            if (exp_v) begin
                checks++; if (dout_a1 !== 32'h0) begin errors++; $display("FAIL clear_scan_data[%0d]: got %h expected 0", c - 2, dout_a1); end
            end
        end
        re_a1 = 1'b0;
    endtask

    task automatic test_latency;
        a_write(1, 32'h10, 32'hDEADBEEF, 4'hF);
        addr_a2 = 32'h10; re_a2 = 1'b1;
        tick;
        re_a2 = 1'b0;
        checks++; if (rvalid_a2 !== 1'b0) begin errors++; $display("FAIL lat_cycle1: got rvalid %b expected 0", rvalid_a2); end
        tick;
        checks++; if (rvalid_a2 !== 1'b0) begin errors++; $display("FAIL lat_cycle2: got rvalid %b expected 0", rvalid_a2); end
        tick;
        checks++; if (rvalid_a2 !== 1'b1 || dout_a2 !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_cycle3: got rvalid %b data %h expected 1 deadbeef", rvalid_a2, dout_a2); end
        tick;
        checks++; if (rvalid_a2 !== 1'b0 || dout_a2 !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_hold: got rvalid %b data %h expected 0 deadbeef", rvalid_a2, dout_a2); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d;
        int          lat;
        a_write(1, 32'h8, 32'h11223344, 4'hF);
        a_write(1, 32'h8, 32'hAABBCCDD, 4'b0101);
        a_read(1, 32'h8, d, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL be_latency: got %0d expected 3", lat); end
        checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h expected 11bb33dd", d); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        int          lat;
        addr_a1 = 32'h20; din_a1 = 32'h1;        be_a1 = 4'b0011; we_a1 = 1'b1;
        addr_a2 = 32'h20; din_a2 = 32'hFFFFFFFF; be_a2 = 4'b1111; we_a2 = 1'b1;
        tick;
        we_a1 = 1'b0; we_a2 = 1'b0; be_a1 = '0; be_a2 = '0;
        a_read(2, 32'h20, d, lat);
        checks++; if (d !== 32'hFFFF0001) begin errors++; $display("FAIL collision: got %h expected ffff0001", d); end
    endtask

    task automatic test_read_first;
        logic [31:0] d;
        int          lat;
        a_write(1, 32'h30, 32'h12345678, 4'hF);
        addr_a1 = 32'h30; din_a1 = 32'hCAFEF00D; be_a1 = 4'hF; we_a1 = 1'b1; re_a1 = 1'b1;
        addr_a2 = 32'h30; re_a2 = 1'b1;
        tick;
        we_a1 = 1'b0; re_a1 = 1'b0; re_a2 = 1'b0; be_a1 = '0;
        tick; tick;
        checks++; if (rvalid_a1 !== 1'b1 || dout_a1 !== 32'h12345678) begin errors++; $display("FAIL read_first_same_port: got %b %h expected 1 12345678", rvalid_a1, dout_a1); end
        checks++; if (rvalid_a2 !== 1'b1 || dout_a2 !== 32'h12345678) begin errors++; $display("FAIL read_first_cross_port: got %b %h expected 1 12345678", rvalid_a2, dout_a2); end
        a_read(2, 32'h30, d, lat);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL read_after_write: got %h expected cafef00d", d); end
    endtask

    task automatic test_errors;
        logic [31:0] d;
        int          lat;
        addr_a1 = 32'h3;          re_a1 = 1'b1;
        addr_a2 = 32'(4 * DEPTH); re_a2 = 1'b1;
        tick;
        re_a1 = 1'b0; re_a2 = 1'b0;
        checks++; if (err_a1 !== 1'b1 || err_a2 !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b%b expected 11", err_a1, err_a2); end
        tick;
        checks++; if (err_a1 !== 1'b0 || err_a2 !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b%b expected 00", err_a1, err_a2); end
        tick;
        checks++; if (rvalid_a1 !== 1'b0 || rvalid_a2 !== 1'b0) begin errors++; $display("FAIL err_no_rvalid: got %b%b expected 00", rvalid_a1, rvalid_a2); end
        // Misaligned write is rejected and must not disturb word 0x10.
        a_write(1, 32'h13, 32'h0, 4'hF);
        checks++; if (err_a1 !== 1'b1) begin errors++; $display("FAIL err_misaligned_write: got %b expected 1", err_a1); end
        // Write with no byte enables is legal and changes nothing.
        a_write(1, 32'h10, 32'h0, 4'h0);
        checks++; if (err_a1 !== 1'b0) begin errors++; $display("FAIL be_zero_no_err: got %b expected 0", err_a1); end
        a_read(1, 32'h10, d, lat);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rejected_write_kept: got %h expected deadbeef", d); end
    endtask

    task automatic test_reset_mid_read;
        bit saw_rv;
        rst_b = 1'b1;
        tick;
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL b_busy: got %b expected 0", busy_b); end
        addr_b1 = 32'h4; din_b1 = 32'hA5A5A5A5; be_b1 = 4'hF; we_b1 = 1'b1;
        tick;
        we_b1 = 1'b0; be_b1 = '0;
        re_b1 = 1'b1;
        tick;
        re_b1 = 1'b0;
        checks++; if (rvalid_b1 !== 1'b0) begin errors++; $display("FAIL b_lat_cycle1: got %b expected 0", rvalid_b1); end
        tick;
        checks++; if (rvalid_b1 !== 1'b1 || dout_b1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL b_lat_cycle2: got %b %h expected 1 a5a5a5a5", rvalid_b1, dout_b1); end
        // Issue a read, then assert reset the next cycle.
        re_b1 = 1'b1;
        tick;
        re_b1 = 1'b0;
        rst_b = 1'b0;
        tick;
        checks++; if (rvalid_b1 !== 1'b0 || dout_b1 !== 32'h0) begin errors++; $display("FAIL midread_reset: got %b %h expected 0 0", rvalid_b1, dout_b1); end
        rst_b = 1'b1;
        saw_rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (rvalid_b1) saw_rv = 1'b1;
        end
        checks++; if (saw_rv || dout_b1 !== 32'h0) begin errors++; $display("FAIL midread_dropped: got rvalid seen %b dout %h expected 0 0", saw_rv, dout_b1); end
        // Contents survive reset when zero-fill is disabled.
        re_b1 = 1'b1;
        tick;
        re_b1 = 1'b0;
        tick;
        checks++; if (rvalid_b1 !== 1'b1 || dout_b1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL b_mem_retained: got %b %h expected 1 a5a5a5a5", rvalid_b1, dout_b1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_latency();
        test_byte_enable();
        test_collision();
        test_read_first();
        test_errors();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_memory.md
DP_MEMORY -- requirements
Module: dp_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16384: number of words, a power of two.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter INIT_CLEAR, default 1: 1 = zero all words after reset.
REQ-006 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have, for each port p in {1,2}, addr_p  input  ADDR_W  byte address.
REQ-009 SHALL have din_p  input  DATA_W  write data.
REQ-010 SHALL have be_p  input  DATA_W/8  byte write enables.
REQ-011 SHALL have re_p  input  1  read request.
REQ-012 SHALL have we_p  input  1  write request.
REQ-013 SHALL have dout_p  output  DATA_W  read data.
REQ-014 SHALL have rvalid_p  output  1  dout_p is valid this cycle.
REQ-015 SHALL have err_p  output  1  one-cycle pulse flagging a rejected request.
REQ-016 SHALL have busy  output  1  high while clearing; requests are ignored while high.

Function
REQ-017 SHALL compute word index = addr_p >> log2(DATA_W/8); a request is legal when the low address bits are zero and index < DEPTH.
REQ-018 SHALL reject an illegal request: no write, no rvalid, and err_p high on the next cycle.
REQ-019 SHALL also reject, with err_p, any request made while busy=1.
REQ-020 SHALL write byte lane b of the word when we_p and be_p[b] are both set; we_p with be_p=0 is a legal no-op.
REQ-021 SHALL present a read issued in cycle N on dout_p with rvalid_p=1 exactly in cycle N+RD_LAT.
REQ-022 SHALL accept back-to-back reads every cycle, one per port, independently per port.
REQ-023 SHALL hold dout_p at its last valid value while rvalid_p=0.
REQ-024 SHALL treat re_p and we_p in the same cycle on the same port as read-first: the read returns the pre-write data.
REQ-025 SHALL make a port-2 read of a word that port 1 writes in the same cycle return the old data, and vice versa.
REQ-026 SHALL resolve both ports writing the same word in one cycle per byte lane: port 1 wins lanes it enables; port 2 writes the remaining enabled lanes.
REQ-027 SHALL implement an FSM with states CLEAR and READY.
REQ-028 SHALL enter CLEAR on reset when INIT_CLEAR=1 and READY otherwise.
REQ-029 SHALL, in CLEAR, zero two words per cycle (indices 2k and 2k+1) and move to READY after DEPTH/2 cycles; busy=1 exactly in CLEAR.
REQ-030 SHALL loop READY to itself until the next reset.

Reset
REQ-031 SHALL, while reset_n=0 at a clock edge, drive rvalid_p=0, err_p=0 and dout_p=0, and flush all read-pipeline stages.
REQ-032 SHALL drive busy=INIT_CLEAR and reset the clear counter to 0 while in reset.
REQ-033 SHALL, on reset mid-read, never deliver any in-flight read.
REQ-034 SHALL, on reset mid-clear, restart clearing from word 0.
REQ-035 SHALL leave memory contents unaffected by reset itself (INIT_CLEAR=0).

Structure
REQ-036 SHALL place the following in package dp_memory_pkg: the FSM state enum (CLEAR, READY), the RD_LAT legal-range constants and the default-parameter constants.
REQ-037 SHALL instantiate sub-module dp_memory_rd_pipe once per port: an RD_LAT-deep valid/data shift pipeline with hold-last-value output.
REQ-038 SHALL fail elaboration for an illegal RD_LAT, a DATA_W that is not a multiple of 8, or a non-power-of-two DEPTH.

Verification
REQ-039 SHALL test: DEPTH=16, INIT_CLEAR=1, release reset -> busy high exactly 8 cycles, then reads of every index return 0.
REQ-040 SHALL test: RD_LAT=3; write 0xDEADBEEF at addr 0x10 on port 1, then read addr 0x10 on port 2 -> rvalid_2 three cycles after the read, dout_2=0xDEADBEEF.
REQ-041 SHALL test: word=0x11223344, port-1 write be=0b0101 din=0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-042 SHALL test: same-cycle writes to addr 0x20, port 1 din=0x1 be=0b0011, port 2 din=0xFFFFFFFF be=0b1111 -> read returns 0xFFFF0001.
REQ-043 SHALL test: read addr 0x3 (misaligned) and addr 4*DEPTH -> err pulses one cycle later, no rvalid.
REQ-044 SHALL test: RD_LAT=2, reset_n=0 one cycle after a read issue -> rvalid never asserts for that read, dout=0.
